// File: rtl/multi_oneshot_blink_if.sv
// multi_oneshot_blink_if: button pins in, press events / LED drive / busy out
interface multi_oneshot_blink_if #(parameter int NUM_CH = 4);
  logic [NUM_CH-1:0] iExtBtn;
  logic [NUM_CH-1:0] oPulse;
  logic [NUM_CH-1:0] oLED;
  logic              oBusy;
  modport master (output iExtBtn, input oPulse, oLED, oBusy);
  modport slave  (input iExtBtn, output oPulse, oLED, oBusy);
endinterface

// File: rtl/multi_oneshot_blink.sv
// multi_oneshot_blink: per-channel sync, debounce, press one-shot and LED blink burst
module multi_oneshot_blink #(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_CYC   = 250000,
  parameter int HALF_PERIOD    = 12500000,
  parameter int BLINK_COUNT    = 3,
  parameter int BTN_ACTIVE_LOW = 1,
  parameter int LED_ACTIVE_LOW = 1
) (
  input logic                   CLK,
  input logic                   RESET,
  multi_oneshot_blink_if.slave  bus
);
  localparam int DW = DEBOUNCE_CYC > 1 ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int PW = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
  localparam int RW = $clog2(BLINK_COUNT + 1) > 0 ? $clog2(BLINK_COUNT + 1) : 1;
  localparam logic BAL = BTN_ACTIVE_LOW != 0;
  localparam logic UNLIT = LED_ACTIVE_LOW != 0;
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  logic [NUM_CH-1:0] w_pulse, w_led, w_busy;
  logic              r_busy;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // pin is normalised so pressed = 1 from the first flop on
    logic          r_s1, r_s2, r_stable, r_pulse, r_led;
    logic [DW-1:0] r_cnt;
    logic [PW-1:0] r_ph, w_ph;
    logic [RW-1:0] r_rem, w_rem;
    state_t        r_state, w_state;
    logic          w_term, w_rise, w_end;
    assign w_term = (r_s2 != r_stable) && r_cnt == DW'(DEBOUNCE_CYC - 1);
    assign w_rise = w_term & r_s2;
    assign w_end  = r_ph == PW'(HALF_PERIOD - 1);
    always_ff @(posedge CLK) begin
      if (RESET) begin
        r_s1     <= 1'b0;
        r_s2     <= 1'b0;
        r_stable <= 1'b0;
        r_cnt    <= '0;
        r_pulse  <= 1'b0;
      end else begin
        r_s1     <= bus.iExtBtn[c] ^ BAL;
        r_s2     <= r_s1;
        r_cnt    <= (r_s2 == r_stable || w_term) ? '0 : r_cnt + 1'b1;
        r_stable <= w_term ? r_s2 : r_stable;
        r_pulse  <= w_rise;
      end
    end
    // a fresh press restarts the burst even on a phase-end edge
    always_comb begin
      w_state = r_state;
      w_ph    = r_ph;
      w_rem   = r_rem;
      if (w_rise) begin
        w_state = ON;
        w_ph    = '0;
        w_rem   = RW'(BLINK_COUNT);
      end else if (r_state == ON) begin
        w_ph    = w_end ? '0 : r_ph + 1'b1;
        w_state = w_end ? OFF : ON;
      end else if (r_state == OFF) begin
        w_ph    = w_end ? '0 : r_ph + 1'b1;
        w_state = !w_end ? OFF : (r_rem == RW'(1)) ? IDLE : ON;
        w_rem   = w_end ? r_rem - 1'b1 : r_rem;
      end
    end
    always_ff @(posedge CLK) begin
      if (RESET) begin
        r_state <= IDLE;
        r_ph    <= '0;
        r_rem   <= '0;
        r_led   <= UNLIT;
      end else begin
        r_state <= w_state;
        r_ph    <= w_ph;
        r_rem   <= w_rem;
        r_led   <= (r_state == ON) ? ~UNLIT : UNLIT;
      end
    end
    assign w_pulse[c] = r_pulse;
    assign w_led[c]   = r_led;
    assign w_busy[c]  = w_state != IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RESET) r_busy <= 1'b0;
    else       r_busy <= |w_busy;
  end
  assign bus.oPulse = w_pulse;
  assign bus.oLED   = w_led;
  assign bus.oBusy  = r_busy;
endmodule
